// File: rtl/req_or_latch.sv
// Request aggregator: per-channel sync + debounce lanes feeding a sticky,
// maskable pending register with OR, first-index and leave-idle pulse outputs.

module req_or_latch_lane #(
   parameter int DEB = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req,
   output logic rise_now
);
   localparam int CW = $clog2(DEB + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB - 1);

   logic          s1, s2, stable;
   logic [CW-1:0] cnt;

   // high on the edge where stable is about to go 0->1
   assign rise_now = s2 & ~stable & (cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         s1 <= req;
         s2 <= s1;
         if (s2 == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module req_or_latch #(
   parameter  int N   = 16,
   parameter  int DEB = 3,
   localparam int IW  = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic          clear,
   output logic [N-1:0]  pending,
   output logic          any,
   output logic [IW-1:0] first_idx,
   output logic          rise
);
   logic [N-1:0]  stable_rise;
   logic [N-1:0]  set;
   logic [N-1:0]  pending_next;
   logic [IW-1:0] low_idx;
   logic          idle;

   for (genvar g = 0; g < N; g++) begin : g_lane
      req_or_latch_lane #(.DEB(DEB)) u_lane (
         .clk      (clk),
         .reset_n  (reset_n),
         .req      (req[g]),
         .rise_now (stable_rise[g])
      );
   end

   assign set          = stable_rise & mask;
   assign pending_next = (clear ? '0 : pending) | set;
   // a same-edge clear counts as idle so a fresh set reloads the index
   assign idle         = clear | ~(|pending);

   always_comb begin
      low_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (set[i]) low_idx = IW'(i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending   <= '0;
         any       <= 1'b0;
         first_idx <= '0;
         rise      <= 1'b0;
      end else begin
         pending <= pending_next;
         any     <= |pending_next;
         rise    <= (|pending_next) & ~any;
         if (idle && (|set)) first_idx <= low_idx;
      end
   end
endmodule

// File: tb/tb_req_or_latch.sv
// Scoreboard bench: expected output snapshots are queued with their due edge
// at stimulus time and checked by a negedge monitor.

module tb_req_or_latch;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] req_a = '0, mask_a = '1;
   logic        clear_a = 1'b0;
   logic [15:0] pend_a;
   logic        any_a, rise_a;
   logic [3:0]  idx_a;
   logic [63:0] req_b = '0, mask_b = '1;
   logic        clear_b = 1'b0;
   logic [63:0] pend_b;
   logic        any_b, rise_b;
   logic [5:0]  idx_b;

   int checks = 0, failures = 0;
   int ecnt = 0, base = 0;

   typedef struct {
      int          due;
      bit          dut;
      string       tag;
      logic [63:0] pend;
      logic        any;
      bit          cidx;
      logic [5:0]  idx;
      logic        rise;
   } exp_t;
   exp_t sb[$];

   req_or_latch #(.N(16), .DEB(3)) u_a (
      .clk(clk), .reset_n(reset_n), .req(req_a), .mask(mask_a), .clear(clear_a),
      .pending(pend_a), .any(any_a), .first_idx(idx_a), .rise(rise_a));

   req_or_latch #(.N(64), .DEB(1)) u_b (
      .clk(clk), .reset_n(reset_n), .req(req_b), .mask(mask_b), .clear(clear_b),
      .pending(pend_b), .any(any_b), .first_idx(idx_b), .rise(rise_b));

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic mark();
      base = ecnt;
   endtask

   // k = edge index relative to the edge following mark(); due after that edge
   task automatic push(input bit d, input int k, input string tag, input logic [63:0] p,
                       input logic a, input bit ci, input logic [5:0] ix, input logic r);
      exp_t e;
      e.due = base + k + 1; e.dut = d; e.tag = tag; e.pend = p;
      e.any = a; e.cidx = ci; e.idx = ix; e.rise = r;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         chk("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == ecnt) begin
            logic [63:0] gp;
            logic        ga, gr;
            logic [5:0]  gi;
            gp = sb[i].dut ? pend_b : {48'b0, pend_a};
            ga = sb[i].dut ? any_b  : any_a;
            gr = sb[i].dut ? rise_b : rise_a;
            gi = sb[i].dut ? idx_b  : {2'b0, idx_a};
            chk({sb[i].tag, "_pend"}, gp, sb[i].pend);
            chk({sb[i].tag, "_any"}, 64'(ga), 64'(sb[i].any));
            chk({sb[i].tag, "_rise"}, 64'(gr), 64'(sb[i].rise));
            if (sb[i].cidx) chk({sb[i].tag, "_idx"}, 64'(gi), 64'(sb[i].idx));
            sb.delete(i);
         end else if (sb[i].due < ecnt) begin
            chk({sb[i].tag, "_stale"}, 64'd1, 64'd0);
            sb.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_pend_a", {48'b0, pend_a}, 64'd0);
      chk("rst_any_a", 64'(any_a), 64'd0);
      chk("rst_idx_a", 64'(idx_a), 64'd0);
      chk("rst_rise_a", 64'(rise_a), 64'd0);
      chk("rst_pend_b", pend_b, 64'd0);
      step(2);
      reset_n = 1'b1;
      step(2);

      // single press, latency DEB+1
      mark(); req_a[5] = 1'b1;
      push(0, 3, "t1_pre", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      push(0, 4, "t1_acc", 64'h20, 1'b1, 1, 6'd5, 1'b1);
      push(0, 5, "t1_hold", 64'h20, 1'b1, 1, 6'd5, 1'b0);
      drain();
      mark(); clear_a = 1'b1;
      push(0, 0, "t1_clr", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      step(1); clear_a = 1'b0; req_a = '0;
      step(8);

      // 2-cycle glitch is filtered
      mark(); req_a[2] = 1'b1;
      for (int k = 1; k <= 8; k++) push(0, k, "t2_glitch", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      step(2); req_a[2] = 1'b0;
      drain();

      // simultaneous sets pick lowest index; later set keeps index
      mark(); req_a[9] = 1'b1; req_a[3] = 1'b1;
      push(0, 4, "t3_dual", 64'h208, 1'b1, 1, 6'd3, 1'b1);
      push(0, 5, "t3_dual_h", 64'h208, 1'b1, 1, 6'd3, 1'b0);
      drain();
      mark(); req_a[1] = 1'b1;
      push(0, 3, "t3_pre", 64'h208, 1'b1, 1, 6'd3, 1'b0);
      push(0, 4, "t3_late", 64'h20a, 1'b1, 1, 6'd3, 1'b0);
      push(0, 5, "t3_late_h", 64'h20a, 1'b1, 1, 6'd3, 1'b0);
      drain();
      mark(); clear_a = 1'b1; req_a = '0;
      push(0, 0, "t3_clr", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      step(1); clear_a = 1'b0;
      step(8);

      // clear on the same edge as a new set
      mark(); req_a[3] = 1'b1;
      push(0, 4, "t4_p8", 64'h8, 1'b1, 1, 6'd3, 1'b1);
      drain();
      mark(); req_a[7] = 1'b1;
      push(0, 3, "t4_pre", 64'h8, 1'b1, 0, 6'd0, 1'b0);
      push(0, 4, "t4_clrset", 64'h80, 1'b1, 1, 6'd7, 1'b0);
      step(4); clear_a = 1'b1;
      step(1); clear_a = 1'b0;
      drain();
      mark(); clear_a = 1'b1; req_a = '0;
      push(0, 0, "t4_clr", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      step(1); clear_a = 1'b0;
      step(8);

      // masked rise is lost; fresh press after unmask is accepted
      mark(); mask_a = 16'hffef; req_a[4] = 1'b1;
      push(0, 4, "t5_masked", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      push(0, 6, "t5_masked2", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      step(6);
      mark(); mask_a = '1;
      for (int k = 0; k < 4; k++) push(0, k, "t5_unmask", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      drain();
      req_a[4] = 1'b0;
      step(8);
      mark(); req_a[4] = 1'b1;
      push(0, 3, "t5_pre", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      push(0, 4, "t5_acc", 64'h10, 1'b1, 1, 6'd4, 1'b1);
      push(0, 5, "t5_hold", 64'h10, 1'b1, 1, 6'd4, 1'b0);
      drain();

      // fill all channels, then async reset mid-cycle with requests held
      mark(); req_a = '1; req_b = 64'h8000_0100_0000_0000;
      push(0, 4, "t6_full", 64'hffff, 1'b1, 1, 6'd4, 1'b0);
      drain();
      chk("t6_pend_b", pend_b, 64'h8000_0100_0000_0000);
      @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("t6_rst_pend_a", {48'b0, pend_a}, 64'd0);
      chk("t6_rst_any_a", 64'(any_a), 64'd0);
      chk("t6_rst_rise_a", 64'(rise_a), 64'd0);
      chk("t6_rst_idx_a", 64'(idx_a), 64'd0);
      chk("t6_rst_pend_b", pend_b, 64'd0);
      chk("t6_rst_any_b", 64'(any_b), 64'd0);
      chk("t6_rst_idx_b", 64'(idx_b), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      mark();
      push(1, 1, "t6b_pre", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      push(1, 2, "t6b_acc", 64'h8000_0100_0000_0000, 1'b1, 1, 6'd40, 1'b1);
      push(1, 3, "t6b_hold", 64'h8000_0100_0000_0000, 1'b1, 1, 6'd40, 1'b0);
      push(0, 3, "t6a_pre", 64'h0, 1'b0, 0, 6'd0, 1'b0);
      push(0, 4, "t6a_acc", 64'hffff, 1'b1, 1, 6'd0, 1'b1);
      push(0, 5, "t6a_hold", 64'hffff, 1'b1, 1, 6'd0, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/req_or_latch.md
# req_or_latch

Parametrised request aggregator for the traffic-light controller. It replaces the fixed 16-input combinational OR with a clocked block that synchronises and debounces N raw request lines (pedestrian buttons, vehicle loop sensors), applies a per-channel enable mask, and holds each accepted request until the FSM clears it. It reports the OR of all held requests, the index of the first request accepted after an idle period, and a one-cycle pulse when the block leaves idle.

## Interface
- N, default 16: number of request channels; legal range 2..64.
- DEB, default 3: debounce length in cycles; legal range 1..255.
- IW, default $clog2(N): width of the index output; derived, not overridden.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N  raw asynchronous request lines, active high.
- mask  input  N  synchronous per-channel enable; 1 = channel may set pending.
- clear  input  1  synchronous; clears all pending bits.
- pending  output  N  sticky accepted requests, registered.
- any  output  1  registered OR of pending.
- first_idx  output  IW  index of the first channel accepted after idle, registered.
- rise  output  1  one-cycle pulse when any goes 0->1, registered.

## Operation
- Per channel: two-flop synchroniser (s1, s2), then debounce filter (stable bit plus counter of width $clog2(DEB+1)).
- Filter, per edge:
  - if s2 == stable: cnt <= 0.
  - else if cnt == DEB-1: stable <= s2, cnt <= 0.
  - else: cnt <= cnt+1.
- A glitch on s2 shorter than DEB cycles never changes stable.
- DEB=1: stable follows s2 with one cycle delay.
- set[i] (combinational) = stable[i] rising this edge (s2=1, stable=0, cnt==DEB-1) AND mask[i].
- pending_next = (clear ? 0 : pending) | set.
  - Set wins over a simultaneous clear for the same channel.
  - Bits only clear via clear or reset. Deasserting mask never clears an existing pending bit.
  - A stable rise while masked is lost; it does not reappear when mask is later set.
- any <= |pending_next. rise <= (|pending_next) & ~any.
- first_idx: loads the lowest index in set on the edge where pending == 0 and set != 0. Otherwise it holds.
  - This includes the edge where a clear coincides with a new set: the new lowest set index loads because the cleared state counts as idle.
  - first_idx is meaningful only while any=1.
- Falling stable edges update the filter only; they have no other effect.

## Timing
- Reset (reset_n=0, immediate, asynchronous):
  - s1, s2, stable, cnt, pending = 0.
  - any = 0, first_idx = 0, rise = 0.
- Latency: req high before edge 0 and held (mask=1) -> pending[i], any, rise visible after edge DEB+1; rise drops after edge DEB+2.
- clear at edge k -> pending=0, any=0 after edge k, unless set occurs at edge k.
- No handshake. clear and mask are sampled every edge and may be held high. A held clear suppresses pending except for same-edge sets, which last one cycle.
- Reset deasserted mid-debounce: the filter restarts from 0; no pending bit appears until a fresh DEB-cycle qualification completes.
- req asserted continuously through reset release: it is accepted DEB+2 edges after release, like a new press.

## Test plan
- N=16, DEB=3, mask=all 1s; assert req[5] before edge 0 and hold. Required: pending=0x0020, any=1, first_idx=5, rise=1 after edge 4; rise=0 after edge 5.
- Pulse req[2] high for 2 cycles only. Required: pending, any and rise stay 0 for the whole run.
- req[9] and req[3] set on the same edge from idle. Required: pending=0x0208, first_idx=3, single rise pulse. Then req[1] accepted later: first_idx stays 3, no rise.
- pending=0x0008; clear asserted on the same edge as req[7]'s set. Required: pending=0x0080, any=1, first_idx=7, no rise.
- mask[4]=0 while req[4] qualifies, then mask[4]=1 with req[4] still high. Required: pending[4] stays 0. Release and re-press req[4]: pending[4]=1 after DEB+2 edges.
- Assert reset_n=0 asynchronously mid-cycle with pending=0xFFFF. Required: all outputs 0 immediately. Release reset with req held: acceptance after DEB+2 edges. Repeat with N=64, DEB=1: acceptance after edge 2.
